bench_sequencer: RTL



---
 rtl/bench_sequencer.sv | 281 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/bench_sequencer.sv
// bench_sequencer: runs a programmable op table through an external executor
// once per condition, timing and checksumming each condition.
// Ports: clk, rst (sync, active-high); run/reps start a sweep; tbl_* write the
// op table while idle; x_* is the executor command and start/done handshake;
// busy/done/timeout_err/cs_mismatch/winner_* report status; rd_cond selects
// the combinational rd_cycles/rd_checksum readback.
module bench_sequencer #(
    parameter int NUM_OPS  = 9,
    parameter int NUM_COND = 4,
    parameter int OPW      = 16,
    parameter int CNTW     = 32,
    parameter int TIMEOUT  = 1024,
    localparam int AW = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1,
    localparam int CW = $clog2(NUM_COND)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [7:0]          reps,
    input  logic                tbl_we,
    input  logic [AW-1:0]       tbl_addr,
    input  logic [3:0]          tbl_opcode,
    input  logic [OPW-1:0]      tbl_a,
    input  logic [OPW-1:0]      tbl_b,
    output logic                x_start,
    output logic [CW-1:0]       x_cond,
    output logic [3:0]          x_opcode,
    output logic [OPW-1:0]      x_a,
    output logic [OPW-1:0]      x_b,
    input  logic                x_done,
    input  logic [31:0]         x_result,
    output logic                busy,
    output logic                done,
    output logic                timeout_err,
    output logic                cs_mismatch,
    output logic [NUM_COND-1:0] winner_onehot,
    output logic [CW-1:0]       winner_idx,
    input  logic [CW-1:0]       rd_cond,
    output logic [CNTW-1:0]     rd_cycles,
    output logic [31:0]         rd_checksum
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WAIT, S_NEXT, S_STORE, S_FIN
    } state_t;

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t r_state;
    state_t w_next;

    logic [3:0]     r_tbl_op [NUM_OPS];
    logic [OPW-1:0] r_tbl_a  [NUM_OPS];
    logic [OPW-1:0] r_tbl_b  [NUM_OPS];

    logic [AW-1:0]   r_op;
    logic [7:0]      r_rep;
    logic [7:0]      r_reps;
    logic [CW-1:0]   r_cond;
    logic [TW-1:0]   r_wcnt;
    logic [CNTW-1:0] r_acc;
    logic [31:0]     r_chk;
    logic            r_to;

    logic [CNTW-1:0]     r_time [NUM_COND];
    logic [31:0]         r_cs   [NUM_COND];
    logic [NUM_COND-1:0] r_tof;

    logic [CW-1:0]       r_x_cond;
    logic [3:0]          r_x_op;
    logic [OPW-1:0]      r_x_a;
    logic [OPW-1:0]      r_x_b;
    logic                r_done;
    logic                r_terr;
    logic                r_mis;
    logic [NUM_COND-1:0] r_win_oh;
    logic [CW-1:0]       r_win_idx;

    logic            w_busy;
    logic            w_idle;
    logic            w_wr_ok;
    logic            w_rd_ok;
    logic            w_tmo;
    logic            w_last_op;
    logic            w_last_rep;
    logic            w_last_cond;
    logic [CNTW-1:0] w_sval;
    logic [CNTW-1:0] w_tn  [NUM_COND];
    logic [31:0]     w_csn [NUM_COND];
    logic [NUM_COND-1:0] w_ton;
    logic [CNTW-1:0] w_best;
    logic [CW-1:0]   w_bidx;
    logic            w_mis;

    assign w_idle  = (r_state == S_IDLE) || (r_state == S_FIN);
    assign w_busy  = !w_idle;
    assign w_wr_ok = tbl_we && w_idle &&
                     ({1'b0, tbl_addr} < (AW+1)'(NUM_OPS));
    assign w_rd_ok = ({1'b0, rd_cond} < (CW+1)'(NUM_COND));
    assign w_tmo   = (r_wcnt == TW'(TIMEOUT - 1));

    assign w_last_op   = (r_op == AW'(NUM_OPS - 1));
    assign w_last_rep  = (r_rep >= r_reps - 8'd1);
    assign w_last_cond = (r_cond == CW'(NUM_COND - 1));
    assign w_sval      = r_to ? '1 : r_acc;

    // Stored results as they will look after this edge, so the winner and
    // mismatch flags can be latched in the same edge as the last STORE.
    always_comb begin
        for (int i = 0; i < NUM_COND; i++) begin
            w_tn[i]  = r_time[i];
            w_csn[i] = r_cs[i];
            w_ton[i] = r_tof[i];
            if (r_state == S_STORE && r_cond == CW'(i)) begin
                w_tn[i]  = w_sval;
                w_csn[i] = r_chk;
                w_ton[i] = r_to;
            end
        end
    end

    // Minimum time; '<=' lets later indices win ties.
    always_comb begin
        w_best = w_tn[0];
        w_bidx = '0;
        for (int i = 1; i < NUM_COND; i++) begin
            if (w_tn[i] <= w_best) begin
                w_best = w_tn[i];
                w_bidx = CW'(i);
            end
        end
    end

    always_comb begin
        w_mis = 1'b0;
        if (!w_ton[0]) begin
            for (int i = 1; i < NUM_COND; i++) begin
                if (!w_ton[i] && (w_csn[i] != w_csn[0]))
                    w_mis = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_FIN: if (run) w_next = S_LOAD;
            S_LOAD:  w_next = S_WAIT;
            S_WAIT:  if (x_done || w_tmo) w_next = S_NEXT;
            S_NEXT:  w_next = (w_last_op && w_last_rep) ? S_STORE : S_LOAD;
            S_STORE: w_next = w_last_cond ? S_FIN : S_LOAD;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_OPS; i++) begin
                r_tbl_op[i] <= '0;
                r_tbl_a[i]  <= '0;
                r_tbl_b[i]  <= '0;
            end
            for (int i = 0; i < NUM_COND; i++) begin
                r_time[i] <= '0;
                r_cs[i]   <= '0;
            end
            r_tof     <= '0;
            r_op      <= '0;
            r_rep     <= '0;
            r_reps    <= 8'd1;
            r_cond    <= '0;
            r_wcnt    <= '0;
            r_acc     <= '0;
            r_chk     <= '0;
            r_to      <= 1'b0;
            r_x_cond  <= '0;
            r_x_op    <= '0;
            r_x_a     <= '0;
            r_x_b     <= '0;
            r_done    <= 1'b0;
            r_terr    <= 1'b0;
            r_mis     <= 1'b0;
            r_win_oh  <= '0;
            r_win_idx <= '0;
        end else begin
            if (w_wr_ok) begin
                r_tbl_op[tbl_addr] <= tbl_opcode;
                r_tbl_a[tbl_addr]  <= tbl_a;
                r_tbl_b[tbl_addr]  <= tbl_b;
            end
            unique case (r_state)
                S_IDLE, S_FIN: begin
                    if (run) begin
                        for (int i = 0; i < NUM_COND; i++) begin
                            r_time[i] <= '0;
                            r_cs[i]   <= '0;
                        end
                        r_tof     <= '0;
                        r_op      <= '0;
                        r_rep     <= '0;
                        r_cond    <= '0;
                        r_reps    <= (reps == 8'd0) ? 8'd1 : reps;
                        r_acc     <= '0;
                        r_chk     <= '0;
                        r_to      <= 1'b0;
                        r_done    <= 1'b0;
                        r_terr    <= 1'b0;
                        r_mis     <= 1'b0;
                        r_win_oh  <= '0;
                        r_win_idx <= '0;
                    end
                end
                S_LOAD: begin
                    r_x_cond <= r_cond;
                    r_x_op   <= r_tbl_op[r_op];
                    r_x_a    <= r_tbl_a[r_op];
                    r_x_b    <= r_tbl_b[r_op];
                    r_wcnt   <= '0;
                end
                S_WAIT: begin
                    r_wcnt <= r_wcnt + TW'(1);
                    if (r_acc != '1)
                        r_acc <= r_acc + CNTW'(1);
                    if (x_done) begin
                        r_chk <= {r_chk[30:0], r_chk[31]} ^ x_result;
                    end else if (w_tmo) begin
                        r_to   <= 1'b1;
                        r_terr <= 1'b1;
                    end
                end
                S_NEXT: begin
                    if (!w_last_op) begin
                        r_op <= r_op + AW'(1);
                    end else if (!w_last_rep) begin
                        r_rep <= r_rep + 8'd1;
                        r_op  <= '0;
                    end
                end
                S_STORE: begin
                    r_time[r_cond] <= w_sval;
                    r_cs[r_cond]   <= r_chk;
                    r_tof[r_cond]  <= r_to;
                    r_acc <= '0;
                    r_chk <= '0;
                    r_to  <= 1'b0;
                    if (w_last_cond) begin
                        r_done    <= 1'b1;
                        r_mis     <= w_mis;
                        r_win_idx <= w_bidx;
                        r_win_oh  <= NUM_COND'(1) << w_bidx;
                    end else begin
                        r_cond <= r_cond + CW'(1);
                        r_op   <= '0;
                        r_rep  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign x_start       = (r_state == S_WAIT) && (r_wcnt == '0);
    assign x_cond        = r_x_cond;
    assign x_opcode      = r_x_op;
    assign x_a           = r_x_a;
    assign x_b           = r_x_b;
    assign busy          = w_busy;
    assign done          = r_done;
    assign timeout_err   = r_terr;
    assign cs_mismatch   = r_mis;
    assign winner_onehot = r_win_oh;
    assign winner_idx    = r_win_idx;
    assign rd_cycles     = w_rd_ok ? r_time[rd_cond] : '0;
    assign rd_checksum   = w_rd_ok ? r_cs[rd_cond] : '0;

endmodule
